// File: rtl/i2c_lux_target.sv
// i2c_lux_target: I2C target emulating a TSL2561-style light sensor.
// A 16x8 register map: 0x0-0xB are bus-writable, and 0xC-0xF return a snapshot
// of the ch0/ch1 ADC words. The snapshot is taken when a read's address is ACKed.
// Ports:
//   clk, reset          100 MHz clock, async active-high reset
//   scl_i, sda_i        async pad inputs (synchronised + glitch filtered)
//   sda_oe              1 = pull SDA low, 0 = release
//   ch0_data, ch1_data  live ADC counts (clk domain)
//   ctrl_out            register 0x0 contents
//   wr_strobe/addr/data one-cycle report of a committed write to 0x0-0xB
//   busy                high from START until STOP
module i2c_lux_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h39,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned HOLD_CYC    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] ch0_data,
  input  logic [15:0] ch1_data,
  output logic [7:0]  ctrl_out,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned HCW = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [1:0]       scl_s, sda_s;
  logic [FCW-1:0]   scl_cnt, sda_cnt;
  logic             scl_f, sda_f, scl_fd, sda_fd;
  logic             scl_rise, scl_fall, start_det, stop_det;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       tx;
  logic             rw;
  logic             first_byte;
  logic             ack_bit;
  logic [3:0]       ptr;
  logic [11:0][7:0] regs;
  logic [31:0]      snap;
  logic             oe_next;
  logic [HCW-1:0]   hold_cnt;
  logic [7:0]       rd_live, rd_snap;

  // Two-flop synchroniser followed by a stability filter on each line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s   <= 2'b11;
      sda_s   <= 2'b11;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_fd  <= 1'b1;
      sda_fd  <= 1'b1;
    end else begin
      scl_s  <= {scl_s[0], scl_i};
      sda_s  <= {sda_s[0], sda_i};
      scl_fd <= scl_f;
      sda_fd <= sda_f;
      if (scl_s[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCW'(FILT_LEN - 1)) begin
        scl_f   <= scl_s[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + FCW'(1);
      end
      if (sda_s[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCW'(FILT_LEN - 1)) begin
        sda_f   <= sda_s[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + FCW'(1);
      end
    end
  end

  assign scl_rise  =  scl_f & ~scl_fd;
  assign scl_fall  = ~scl_f &  scl_fd;
  assign start_det = ~sda_f &  sda_fd & scl_f;
  assign stop_det  =  sda_f & ~sda_fd & scl_f;

  // Register map read mux; 0xC-0xF come from the given 32-bit {ch1,ch0} word
  function automatic logic [7:0] rd_mux(input logic [3:0] p,
                                        input logic [31:0] s,
                                        input logic [11:0][7:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (p)
      4'hC:    v = s[7:0];
      4'hD:    v = s[15:8];
      4'hE:    v = s[23:16];
      4'hF:    v = s[31:24];
      default: v = r[p];
    endcase
    return v;
  endfunction

  // First read byte uses the live ADC words because the snapshot loads on the same edge
  assign rd_live = rd_mux(ptr, {ch1_data, ch0_data}, regs);
  assign rd_snap = rd_mux(ptr, snap, regs);
  assign ctrl_out = regs[0];

  // Protocol FSM: bits sampled on SCL rise, next SDA level chosen on SCL fall
  // and applied HOLD_CYC cycles later through hold_cnt/oe_next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ack_bit    <= 1'b1;
      ptr        <= '0;
      regs       <= '0;
      snap       <= '0;
      oe_next    <= 1'b0;
      hold_cnt   <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HCW'(1);
        if (hold_cnt == HCW'(1)) sda_oe <= oe_next;
      end

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        busy     <= 1'b1;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (stop_det) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else begin
        if (scl_rise) begin
          case (state)
            ADDR, WR_BYTE: begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end
            RD_BYTE: bit_cnt <= bit_cnt + 4'd1;
            RD_ACK:  ack_bit <= sda_f;
            WR_ACK: begin
              // Commit on the ACK clock so an aborted byte never writes
              if (first_byte) begin
                ptr        <= shift[3:0];
                first_byte <= 1'b0;
              end else begin
                if (ptr <= 4'hB) begin
                  regs[ptr] <= shift;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= shift;
                end
                ptr <= ptr + 4'd1;
              end
            end
            default: ;
          endcase
        end

        if (scl_fall) begin
          hold_cnt <= HCW'(HOLD_CYC);
          oe_next  <= 1'b0;
          case (state)
            ADDR: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                if (shift[7:1] == TARGET_ADDR) begin
                  rw      <= shift[0];
                  state   <= ADDR_ACK;
                  oe_next <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end
            ADDR_ACK: begin
              bit_cnt <= '0;
              if (rw) begin
                snap    <= {ch1_data, ch0_data};
                tx      <= {rd_live[6:0], 1'b0};
                oe_next <= ~rd_live[7];
                state   <= RD_BYTE;
              end else begin
                first_byte <= 1'b1;
                state      <= WR_BYTE;
              end
            end
            WR_BYTE: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                oe_next <= 1'b1;
                state   <= WR_ACK;
              end
            end
            WR_ACK: begin
              bit_cnt <= '0;
              state   <= WR_BYTE;
            end
            RD_BYTE: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                ptr     <= ptr + 4'd1;
                state   <= RD_ACK;
              end else begin
                oe_next <= ~tx[7];
                tx      <= {tx[6:0], 1'b0};
              end
            end
            RD_ACK: begin
              bit_cnt <= '0;
              if (!ack_bit) begin
                tx      <= {rd_snap[6:0], 1'b0};
                oe_next <= ~rd_snap[7];
                state   <= RD_BYTE;
              end else begin
                state <= IGNORE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_lux_target.sv
// Bench for i2c_lux_target: a bit-banged I2C initiator drives the bus, while
// scoreboard queues of expected bus responses and write strobes are consumed
// by monitor processes.
module tb_i2c_lux_target;

  localparam int Q = 25;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        scl_m, sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] ch0_data, ch1_data;
  logic [7:0]  ctrl_out;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_lux_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .ch0_data (ch0_data),
    .ch1_data (ch1_data),
    .ctrl_out (ctrl_out),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  typedef struct { string name; logic [8:0] val; } exp_t;
  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;

  exp_t       exp_q[$];
  logic [8:0] obs_q[$];
  wr_t        wr_exp_q[$];
  event       obs_ev;

  int checks = 0;
  int passes = 0;
  logic oe_watch = 1'b0;
  int   oe_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Bus response checker: pairs each observed ACK/byte with the next expectation
  initial begin
    exp_t       e;
    logic [8:0] v;
    forever begin
      @(obs_ev);
      while (obs_q.size() != 0) begin
        v = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: got 0x%0h expected nothing", v);
        end else begin
          e = exp_q.pop_front();
          check(e.name, 32'(v), 32'(e.val));
        end
      end
    end
  end

  // Write strobe monitor
  always @(negedge clk) begin
    wr_t w;
    if (!reset && wr_strobe) begin
      if (wr_exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        w = wr_exp_q.pop_front();
        check("strobe_addr", 32'(wr_addr), 32'(w.a));
        check("strobe_data", 32'(wr_data), 32'(w.d));
      end
    end
    if (oe_watch && sda_oe) oe_seen++;
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic drive, output logic smp);
    sda_m = drive; q_wait();
    scl_m = 1'b1;  q_wait();
    smp = sda_line; q_wait();
    scl_m = 1'b0;  q_wait();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    exp_q.push_back('{name, 9'(exp_ack)});
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    obs_q.push_back(9'(s));
    ->obs_ev;
  endtask

  task automatic recv(input logic nack, input logic [7:0] exp_b, input string name);
    logic       s;
    logic [7:0] d;
    d = '0;
    exp_q.push_back('{name, 9'(exp_b)});
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    bus_bit(nack, s);
    obs_q.push_back(9'(d));
    ->obs_ev;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    ch0_data = 16'h0000; ch1_data = 16'h0000;
    repeat (5) @(negedge clk);
    check("rst_sda_oe",    32'(sda_oe),    32'd0);
    check("rst_ctrl_out",  32'(ctrl_out),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Write 0x03 to control register
    i2c_start();
    check("t1_busy_start", 32'(busy), 32'd1);
    wr_exp_q.push_back('{4'h0, 8'h03});
    send(8'h72, 1'b0, "t1_addr_ack");
    send(8'h00, 1'b0, "t1_ptr_ack");
    send(8'h03, 1'b0, "t1_data_ack");
    i2c_stop();
    check("t1_ctrl_out",  32'(ctrl_out), 32'h03);
    check("t1_busy_stop", 32'(busy), 32'd0);
    check("t1_strobes",   32'(wr_exp_q.size()), 32'd0);

    // Read ADC words through 0xC-0xF with repeated START; pointer wraps to 0
    ch0_data = 16'h1234; ch1_data = 16'h0567;
    i2c_start();
    send(8'h72, 1'b0, "t2_waddr_ack");
    send(8'h0C, 1'b0, "t2_ptr_ack");
    i2c_start();
    send(8'h73, 1'b0, "t2_raddr_ack");
    check("t2_busy", 32'(busy), 32'd1);
    recv(1'b0, 8'h34, "t2_rd_c");
    recv(1'b0, 8'h12, "t2_rd_d");
    recv(1'b0, 8'h67, "t2_rd_e");
    recv(1'b1, 8'h05, "t2_rd_f");
    i2c_stop();
    i2c_start();
    send(8'h73, 1'b0, "t2b_raddr_ack");
    recv(1'b1, 8'h03, "t2b_rd_wrap0");
    i2c_stop();

    // ch0 changes after the address ACK must not affect the read
    i2c_start();
    send(8'h72, 1'b0, "t3_waddr_ack");
    send(8'h0C, 1'b0, "t3_ptr_ack");
    i2c_start();
    send(8'h73, 1'b0, "t3_raddr_ack");
    ch0_data = 16'hFFFF;
    recv(1'b0, 8'h34, "t3_rd_c_snap");
    recv(1'b1, 8'h12, "t3_rd_d_snap");
    i2c_stop();
    ch0_data = 16'h1234;

    // Foreign address: NACK, SDA never pulled, busy until STOP
    oe_seen = 0; oe_watch = 1'b1;
    i2c_start();
    send(8'h52, 1'b1, "t4_foreign_nack");
    check("t4_busy_before_stop", 32'(busy), 32'd1);
    i2c_stop();
    oe_watch = 1'b0;
    check("t4_oe_never", 32'(oe_seen), 32'd0);
    check("t4_busy_after_stop", 32'(busy), 32'd0);

    // Write at 0xB: second byte hits read-only 0xC, ACKed and dropped
    wr_exp_q.push_back('{4'hB, 8'hAA});
    i2c_start();
    send(8'h72, 1'b0, "t5_addr_ack");
    send(8'h0B, 1'b0, "t5_ptr_ack");
    send(8'hAA, 1'b0, "t5_d0_ack");
    send(8'h55, 1'b0, "t5_d1_ack");
    i2c_stop();
    check("t5_strobes", 32'(wr_exp_q.size()), 32'd0);
    i2c_start();
    send(8'h73, 1'b0, "t5_raddr_ack");
    recv(1'b1, 8'h12, "t5_rd_ptr_d");
    i2c_stop();
    i2c_start();
    send(8'h72, 1'b0, "t5b_waddr_ack");
    send(8'h0B, 1'b0, "t5b_ptr_ack");
    i2c_start();
    send(8'h73, 1'b0, "t5b_raddr_ack");
    recv(1'b0, 8'hAA, "t5b_rd_b");
    recv(1'b1, 8'h34, "t5b_rd_c");
    i2c_stop();

    // Write pointer wraps 0xF -> 0x0
    wr_exp_q.push_back('{4'h0, 8'h22});
    i2c_start();
    send(8'h72, 1'b0, "t6_addr_ack");
    send(8'h0F, 1'b0, "t6_ptr_ack");
    send(8'h11, 1'b0, "t6_d0_ack");
    send(8'h22, 1'b0, "t6_d1_ack");
    i2c_stop();
    check("t6_ctrl_out", 32'(ctrl_out), 32'h22);
    check("t6_strobes",  32'(wr_exp_q.size()), 32'd0);

    // Async reset while driving a 0 data bit
    i2c_start();
    send(8'h72, 1'b0, "t7_waddr_ack");
    send(8'h00, 1'b0, "t7_ptr_ack");
    i2c_start();
    send(8'h73, 1'b0, "t7_raddr_ack");
    sda_m = 1'b1;
    check("t7_oe_bit7", 32'(sda_oe), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t7_oe_async", 32'(sda_oe), 32'd0);
    check("t7_busy_async", 32'(busy), 32'd0);
    check("t7_ctrl_async", 32'(ctrl_out), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    i2c_start();
    send(8'h73, 1'b0, "t7_raddr2_ack");
    recv(1'b1, 8'h00, "t7_rd_reg0");
    i2c_stop();

    repeat (50) @(negedge clk);
    check("rsp_drained", 32'(exp_q.size()), 32'd0);
    check("wr_drained",  32'(wr_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
